// File: rtl/dram_pkg.sv
// Shared defaults and types for the DRAM responder slice.
package dram_pkg;

  localparam int DATA_W         = 32;
  localparam int ADDR_W         = 18;
  localparam int DEPTH_DEF      = 131072;
  localparam int RD_LATENCY_DEF = 2;
  localparam int MAX_RD_LATENCY = 8;

  typedef enum logic {
    SRC_CORE = 1'b0,
    SRC_HOST = 1'b1
  } src_e;

  // Default-width layout of one read-pipe stage: {valid, src, data}.
  typedef struct packed {
    logic              valid;
    src_e              src;
    logic [DATA_W-1:0] data;
  } pipe_stage_t;

  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/dram_rd_pipe.sv
// Read-return pipeline: stage 0 pairs the registered request tag with the array
// output, later stages are plain registers cleared by the asynchronous reset.
module dram_rd_pipe
  import dram_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int RD_LATENCY = RD_LATENCY_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  src_e                  req_src,
  input  logic                  req_ok,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic                  out_valid,
  output src_e                  out_src,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy
);

  typedef struct packed {
    logic                  valid;
    src_e                  src;
    logic [DATA_WIDTH-1:0] data;
  } stage_t;

  logic   s0_valid;
  logic   s0_ok;
  src_e   s0_src;
  stage_t head;
  stage_t tail;
  logic   tail_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s0_ok    <= 1'b0;
      s0_src   <= SRC_CORE;
    end else begin
      s0_valid <= req;
      s0_ok    <= req & req_ok;
      s0_src   <= req_src;
    end
  end

  // Out-of-range reads still travel the pipe, but carry zero data.
  always_comb begin
    head       = '0;
    head.valid = s0_valid;
    head.src   = s0_src;
    head.data  = s0_ok ? ram_q : '0;
  end

  generate
    if (RD_LATENCY <= 1) begin : g_direct
      assign tail      = head;
      assign tail_busy = 1'b0;
    end else begin : g_regs
      stage_t q [RD_LATENCY-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < RD_LATENCY - 1; i++) q[i] <= '0;
        end else begin
          q[0] <= head;
          for (int i = 1; i < RD_LATENCY - 1; i++) q[i] <= q[i-1];
        end
      end

      always_comb begin
        tail_busy = 1'b0;
        for (int i = 0; i < RD_LATENCY - 1; i++) tail_busy = tail_busy | q[i].valid;
      end

      assign tail = q[RD_LATENCY-2];
    end
  endgenerate

  assign out_valid = tail.valid;
  assign out_src   = tail.src;
  assign out_data  = tail.data;
  assign busy      = s0_valid | tail_busy;

endmodule

// File: rtl/dram_responder.sv
// Memory-side responder for the accelerator DRAM port: core read/write path with
// fixed read latency, plus a host port that only gets the array when the core is idle.
module dram_responder
  import dram_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int RD_LATENCY = RD_LATENCY_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_rd,
  input  logic [ADDR_WIDTH-1:0] addr_rd,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  en_wr,
  input  logic [ADDR_WIDTH-1:0] addr_wr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  host_en,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_rvalid,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_busy,
  output logic                  addr_err
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [1:0]            rst_sync;
  logic                  rst_int;
  logic                  pipe_busy;
  logic                  host_acc;
  logic                  host_rd;
  logic                  host_wr;
  logic                  rd_req;
  logic                  wr_req;
  logic                  rd_ok;
  logic                  wr_ok;
  src_e                  rd_src;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  out_valid;
  src_e                  out_src;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  core_hit;
  logic                  host_hit;
  logic [DATA_WIDTH-1:0] core_hold;
  logic [DATA_WIDTH-1:0] host_hold;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Reset asserts immediately but is released two clocks after rst drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_sync <= 2'b11;
    else     rst_sync <= {rst_sync[0], 1'b0};
  end
  assign rst_int = rst_sync[1];

  // The core always wins; the host only gets a slot when nothing core-side is live.
  assign host_busy = en_rd | en_wr | pipe_busy;
  assign host_acc  = host_en & ~host_busy;
  assign host_rd   = host_acc & ~host_we;
  assign host_wr   = host_acc & host_we;

  assign rd_req  = en_rd | host_rd;
  assign rd_addr = en_rd ? addr_rd : host_addr;
  assign rd_src  = en_rd ? SRC_CORE : SRC_HOST;
  assign wr_req  = en_wr | host_wr;
  assign wr_addr = en_wr ? addr_wr : host_addr;
  assign wr_data = en_wr ? data_in : host_wdata;

  assign rd_ok = addr_in_range(32'(rd_addr), DEPTH);
  assign wr_ok = addr_in_range(32'(wr_addr), DEPTH);

  // Read is sampled before the write lands, so a same-address pair returns old data.
  always_ff @(posedge clk) begin
    if (rd_req) ram_q <= mem[rd_addr[IDX_W-1:0]];
    if (wr_req && wr_ok) mem[wr_addr[IDX_W-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) addr_err <= 1'b0;
    else if ((rd_req && !rd_ok) || (wr_req && !wr_ok)) addr_err <= 1'b1;
  end

  dram_rd_pipe #(
    .DATA_WIDTH(DATA_WIDTH),
    .RD_LATENCY(RD_LATENCY)
  ) u_rd_pipe (
    .clk      (clk),
    .rst      (rst_int),
    .req      (rd_req),
    .req_src  (rd_src),
    .req_ok   (rd_ok),
    .ram_q    (ram_q),
    .out_valid(out_valid),
    .out_src  (out_src),
    .out_data (out_data),
    .busy     (pipe_busy)
  );

  assign core_hit = out_valid && (out_src == SRC_CORE);
  assign host_hit = out_valid && (out_src == SRC_HOST);

  // Each port keeps showing its last returned word while its valid is low.
  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      core_hold <= '0;
      host_hold <= '0;
    end else begin
      if (core_hit) core_hold <= out_data;
      if (host_hit) host_hold <= out_data;
    end
  end

  assign valid       = core_hit;
  assign data_out    = core_hit ? out_data : core_hold;
  assign host_rvalid = host_hit;
  assign host_rdata  = host_hit ? out_data : host_hold;

endmodule

// File: tb/tb_dram_responder.sv
// Directed and randomized bench for dram_responder against a cycle-scheduled
// reference model of the memory and its two ports.
module tb_dram_responder;

  localparam int L     = 2;
  localparam int DEPTH = 131072;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en_rd;
  logic [17:0] addr_rd;
  logic        valid;
  logic [31:0] data_out;
  logic        en_wr;
  logic [17:0] addr_wr;
  logic [31:0] data_in;
  logic        host_en;
  logic        host_we;
  logic [17:0] host_addr;
  logic [31:0] host_wdata;
  logic        host_rvalid;
  logic [31:0] host_rdata;
  logic        host_busy;
  logic        addr_err;

  dram_responder dut (
    .clk        (clk),
    .rst        (rst),
    .en_rd      (en_rd),
    .addr_rd    (addr_rd),
    .valid      (valid),
    .data_out   (data_out),
    .en_wr      (en_wr),
    .addr_wr    (addr_wr),
    .data_in    (data_in),
    .host_en    (host_en),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rvalid(host_rvalid),
    .host_rdata (host_rdata),
    .host_busy  (host_busy),
    .addr_err   (addr_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: word store, responses keyed by the cycle they are due.
  int          cyc     = 0;
  int          last_rd = -100;
  logic [31:0] mem_m     [int];
  logic [31:0] core_due  [int];
  logic [31:0] host_due  [int];
  logic [31:0] exp_data_out   = '0;
  logic [31:0] exp_host_rdata = '0;
  logic        exp_err        = 1'b0;
  int          core_valid_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic in_rng(input logic [17:0] a);
    return int'(a) < DEPTH;
  endfunction

  function automatic logic model_busy();
    return en_rd || en_wr || ((cyc - last_rd) <= L);
  endfunction

  task automatic idle();
    en_rd = 0; addr_rd = '0; en_wr = 0; addr_wr = '0; data_in = '0;
    host_en = 0; host_we = 0; host_addr = '0; host_wdata = '0;
  endtask

  task automatic model_reset();
    core_due.delete();
    host_due.delete();
    exp_data_out   = '0;
    exp_host_rdata = '0;
    exp_err        = 1'b0;
    last_rd        = cyc - 100;
  endtask

  // One clock: check busy, apply the model at the edge, check outputs after it.
  task automatic tick();
    logic        b;
    logic        acc;
    logic [31:0] rd;
    #1;
    b = model_busy();
    check("host_busy", host_busy, b);
    @(posedge clk);
    acc = host_en && !b;
    if (en_rd) begin
      rd = in_rng(addr_rd) ? mem_m[int'(addr_rd)] : 32'h0;
      core_due[cyc + L] = rd;
      last_rd = cyc;
      if (!in_rng(addr_rd)) exp_err = 1'b1;
    end else if (acc && !host_we) begin
      rd = in_rng(host_addr) ? mem_m[int'(host_addr)] : 32'h0;
      host_due[cyc + L] = rd;
      last_rd = cyc;
      if (!in_rng(host_addr)) exp_err = 1'b1;
    end
    if (en_wr) begin
      if (in_rng(addr_wr)) mem_m[int'(addr_wr)] = data_in;
      else exp_err = 1'b1;
    end else if (acc && host_we) begin
      if (in_rng(host_addr)) mem_m[int'(host_addr)] = host_wdata;
      else exp_err = 1'b1;
    end
    cyc++;
    @(negedge clk);
    if (core_due.exists(cyc)) begin
      exp_data_out = core_due[cyc];
      core_due.delete(cyc);
      check("valid", valid, 1);
    end else begin
      check("valid", valid, 0);
    end
    check("data_out", data_out, exp_data_out);
    if (host_due.exists(cyc)) begin
      exp_host_rdata = host_due[cyc];
      host_due.delete(cyc);
      check("host_rvalid", host_rvalid, 1);
    end else begin
      check("host_rvalid", host_rvalid, 0);
    end
    check("host_rdata", host_rdata, exp_host_rdata);
    check("addr_err", addr_err, exp_err);
    if (valid) core_valid_seen++;
  endtask

  // Assert reset mid-cycle, hold it, release it and let the synchronizer drain.
  task automatic reset_hold(input logic [17:0] third_addr);
    #2 rst = 1'b1;
    #1;
    check("rst_valid", valid, 0);
    check("rst_data_out", data_out, 0);
    check("rst_host_rvalid", host_rvalid, 0);
    check("rst_host_rdata", host_rdata, 0);
    check("rst_addr_err", addr_err, 0);
    @(posedge clk); cyc++;
    @(negedge clk);
    check("rst_valid_hold", valid, 0);
    addr_rd = third_addr;
    @(posedge clk); cyc++;
    @(negedge clk);
    check("rst_valid_hold", valid, 0);
    idle();
    repeat (2) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      check("rst_valid_hold", valid, 0);
    end
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      check("post_rst_valid", valid, 0);
      check("post_rst_data_out", data_out, 0);
    end
    model_reset();
  endtask

  function automatic logic [17:0] rand_addr();
    if ($urandom_range(19) == 0) return 18'(DEPTH + int'($urandom_range(1000)));
    return 18'($urandom_range(783));
  endfunction

  initial begin
    idle();
    @(negedge clk);
    reset_hold(18'h0);

    // Host preload then a core read of the same word.
    host_en = 1; host_we = 1; host_addr = 18'h10; host_wdata = 32'hDEADBEEF;
    tick();
    idle(); en_rd = 1; addr_rd = 18'h10;
    tick();
    idle();
    tick();
    check("lat_data", data_out, 32'hDEADBEEF);
    tick();

    // Three reads with reset landing on the second one.
    en_rd = 1; addr_rd = 18'h10;
    tick();
    addr_rd = 18'h11;
    reset_hold(18'h12);

    // Preload addr*3 over the host port, then a back-to-back core burst.
    for (int a = 0; a < 784; a++) begin
      idle(); host_en = 1; host_we = 1; host_addr = 18'(a); host_wdata = 32'(a * 3);
      tick();
    end
    idle();
    core_valid_seen = 0;
    for (int a = 0; a < 784; a++) begin
      en_rd = 1; addr_rd = 18'(a);
      tick();
    end
    idle();
    repeat (L + 1) tick();
    check("burst_valid_count", 32'(core_valid_seen), 32'd784);

    // Same-address read and write in one cycle.
    host_en = 1; host_we = 1; host_addr = 18'd5; host_wdata = 32'hAAAA;
    tick();
    idle(); en_wr = 1; addr_wr = 18'd5; data_in = 32'h1234; en_rd = 1; addr_rd = 18'd5;
    tick();
    idle();
    tick(); tick();
    check("rbw_old", data_out, 32'hAAAA);
    en_rd = 1; addr_rd = 18'd5;
    tick();
    idle();
    tick(); tick();
    check("rbw_new", data_out, 32'h1234);

    // Out-of-range read and a dropped out-of-range write that must not alias.
    en_rd = 1; addr_rd = 18'd131072;
    tick();
    idle();
    tick(); tick();
    check("oor_data", data_out, 32'h0);
    check("oor_err", addr_err, 1);
    en_wr = 1; addr_wr = 18'd131073; data_in = 32'h5555;
    tick();
    idle(); en_rd = 1; addr_rd = 18'd1;
    tick();
    idle();
    tick(); tick();
    check("oor_no_alias", data_out, 32'd3);

    // Host write while the core reads is dropped; retried when idle it lands.
    en_rd = 1; addr_rd = 18'h20;
    host_en = 1; host_we = 1; host_addr = 18'h20; host_wdata = 32'hCAFEF00D;
    #1;
    check("busy_core", host_busy, 1);
    tick();
    idle();
    repeat (L + 1) tick();
    check("busy_dropped", data_out, 32'h60);
    host_en = 1; host_we = 1; host_addr = 18'h20; host_wdata = 32'hCAFEF00D;
    tick();
    idle(); host_en = 1; host_we = 0; host_addr = 18'h20;
    tick();
    idle();
    repeat (L + 1) tick();
    check("host_retry", host_rdata, 32'hCAFEF00D);

    // Randomized traffic on both ports.
    for (int n = 0; n < 400; n++) begin
      idle();
      en_rd      = ($urandom_range(2) == 0);
      addr_rd    = rand_addr();
      en_wr      = ($urandom_range(3) == 0);
      addr_wr    = rand_addr();
      data_in    = $urandom;
      host_en    = ($urandom_range(1) == 1);
      host_we    = ($urandom_range(1) == 1);
      host_addr  = rand_addr();
      host_wdata = $urandom;
      tick();
    end
    idle();
    repeat (L + 2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
